// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline constants for operand forwarding and load-use detection.
package fwd_hazard_unit_pkg;

  // Register-number width of the five-stage pipeline.
  localparam int REG_W = 5;

  // Select codes for the 3x1 operand-forwarding muxes in EX.
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;  // register-file read data
  localparam fwd_sel_t FWD_MEM = 2'b01;  // ALU result now in MEM
  localparam fwd_sel_t FWD_WB  = 2'b10;  // write data now in WB

  // $0 is hard-wired to zero and never produces a value worth forwarding.
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage : fwd_hazard_unit_pkg

// File: rtl/fwd_select.sv
// Single-operand forwarding comparator: picks MEM, WB or the register file
// for one EX source register. MEM is checked first because it holds the
// younger value when both stages write the same register.
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int SEL_REG_W = fwd_hazard_unit_pkg::REG_W
) (
  input  logic [SEL_REG_W-1:0] src,
  input  logic [SEL_REG_W-1:0] mem_dest,
  input  logic                 mem_reg_write,
  input  logic [SEL_REG_W-1:0] wb_dest,
  input  logic                 wb_reg_write,
  output fwd_sel_t             sel
);

  logic mem_hit;
  logic wb_hit;

  // A stage whose destination is $0 behaves as a non-writing stage.
  always_comb begin
    mem_hit = mem_reg_write && (mem_dest != '0) && (mem_dest == src);
    wb_hit  = wb_reg_write  && (wb_dest  != '0) && (wb_dest  == src);
  end

  // Priority select: MEM over WB over register file; 11 is never produced.
  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule : fwd_select

// File: rtl/fwd_hazard_unit.sv
// Data-hazard control for the five-stage pipeline: tracks the EX write
// destination through MEM and WB, drives the EX operand-forwarding selects,
// and raises a one-cycle load-use stall. No FSM is needed for the stall:
// once the load moves to MEM and a bubble sits in EX, the request drops.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_W = fwd_hazard_unit_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Freeze,
  input  logic [REG_W-1:0] IDRs,
  input  logic [REG_W-1:0] IDRt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic [REG_W-1:0] EXRs,
  input  logic [REG_W-1:0] EXRt,
  input  logic [REG_W-1:0] EXDest,
  input  logic             EXRegWrite,
  input  logic             EXMemRead,
  input  logic             Flush,
  output fwd_sel_t         ForwardA,
  output fwd_sel_t         ForwardB,
  output logic             Stall,
  output logic [REG_W-1:0] MEMDest,
  output logic [REG_W-1:0] WBDest,
  output logic             MEMRegWrite,
  output logic             WBRegWrite,
  output logic [CNT_W-1:0] StallCount
);

  // Tracking registers. Whether the MEM instruction is a load is not kept:
  // no output depends on it, since a MEM-stage load match still selects 01.
  logic [REG_W-1:0] mem_dest_q,      mem_dest_d;
  logic             mem_reg_write_q, mem_reg_write_d;
  logic [REG_W-1:0] wb_dest_q,       wb_dest_d;
  logic             wb_reg_write_q,  wb_reg_write_d;
  logic [CNT_W-1:0] stall_count_q,   stall_count_d;

  logic ex_is_load;
  logic id_rs_dep;
  logic id_rt_dep;
  logic stall;

  // Operand A and B comparators share the same tracked MEM/WB state.
  fwd_select #(
    .SEL_REG_W     (REG_W)
  ) u_fwd_a (
    .src           (EXRs),
    .mem_dest      (mem_dest_q),
    .mem_reg_write (mem_reg_write_q),
    .wb_dest       (wb_dest_q),
    .wb_reg_write  (wb_reg_write_q),
    .sel           (ForwardA)
  );

  fwd_select #(
    .SEL_REG_W     (REG_W)
  ) u_fwd_b (
    .src           (EXRt),
    .mem_dest      (mem_dest_q),
    .mem_reg_write (mem_reg_write_q),
    .wb_dest       (wb_dest_q),
    .wb_reg_write  (wb_reg_write_q),
    .sel           (ForwardB)
  );

  // Load-use detection; a flushed ID instruction never stalls.
  always_comb begin
    ex_is_load = EXMemRead && EXRegWrite && (EXDest != '0);
    id_rs_dep  = IDUsesRs && (IDRs == EXDest);
    id_rt_dep  = IDUsesRt && (IDRt == EXDest);
    stall      = ex_is_load && (id_rs_dep || id_rt_dep) && !Flush;
  end

  // Next-state for tracking registers and the saturating stall counter;
  // Freeze holds everything.
  always_comb begin
    mem_dest_d      = mem_dest_q;
    mem_reg_write_d = mem_reg_write_q;
    wb_dest_d       = wb_dest_q;
    wb_reg_write_d  = wb_reg_write_q;
    stall_count_d   = stall_count_q;
    if (!Freeze) begin
      mem_dest_d      = EXDest;
      mem_reg_write_d = EXRegWrite;
      wb_dest_d       = mem_dest_q;
      wb_reg_write_d  = mem_reg_write_q;
      if (stall && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + 1'b1;
      end
    end
  end

  // State register; reset discards every in-flight destination.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_dest_q      <= '0;
      mem_reg_write_q <= 1'b0;
      wb_dest_q       <= '0;
      wb_reg_write_q  <= 1'b0;
      stall_count_q   <= '0;
    end else begin
      mem_dest_q      <= mem_dest_d;
      mem_reg_write_q <= mem_reg_write_d;
      wb_dest_q       <= wb_dest_d;
      wb_reg_write_q  <= wb_reg_write_d;
      stall_count_q   <= stall_count_d;
    end
  end

  // Output wiring of tracked state.
  always_comb begin
    Stall       = stall;
    MEMDest     = mem_dest_q;
    MEMRegWrite = mem_reg_write_q;
    WBDest      = wb_dest_q;
    WBRegWrite  = wb_reg_write_q;
    StallCount  = stall_count_q;
  end

endmodule : fwd_hazard_unit

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Data-hazard control for the five-stage pipeline. Tracks the destination register chosen by the 5-bit write-register select mux (rt / rd / $31) as it moves from EX through MEM to WB. Produces the 2-bit select codes that drive the 3x1 forwarding muxes on the ALU operands, plus a one-cycle load-use stall request to the IF/ID and ID/EX stage control. Sits between the write-register mux output and the operand-forwarding muxes in EX.

## Interface
- REG_W, 5, register-number width
- CNT_W, 16, width of the stall performance counter
- Clk  in  1  pipeline clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Freeze  in  1  global pipeline hold; when 1, no internal state advances
- IDRs, IDRt  in  REG_W  source registers of the instruction in ID
- IDUsesRs, IDUsesRt  in  1  the ID instruction actually reads that source
- EXRs, EXRt  in  REG_W  source registers of the instruction in EX
- EXDest  in  REG_W  output of the write-register mux for the instruction in EX
- EXRegWrite, EXMemRead  in  1  control bits of the instruction in EX
- Flush  in  1  taken branch or jump; the ID instruction is being killed
- ForwardA, ForwardB  out  2  operand select: 00 register file, 01 MEM-stage ALU result, 10 WB-stage write data; 11 never driven
- Stall  out  1  load-use hazard; hold PC and IF/ID, insert bubble into ID/EX
- MEMDest, WBDest  out  REG_W  tracked destinations
- MEMRegWrite, WBRegWrite  out  1  tracked write enables
- StallCount  out  CNT_W  number of stall cycles issued, saturating

## Operation
- Tracking registers: {MEMDest, MEMRegWrite, MEMMemRead} and {WBDest, WBRegWrite}.
- Each rising edge with Freeze=0: MEM fields <= EX inputs, and WB fields <= MEM fields.
- Each rising edge with Freeze=1: all tracking registers and StallCount hold.
- A destination of 0 is never a forwarding or stall source. Any stage whose Dest is 0 counts as non-writing.
- ForwardA, combinational:
  - 01 if MEMRegWrite && MEMDest!=0 && MEMDest==EXRs
  - else 10 if WBRegWrite && WBDest!=0 && WBDest==EXRs
  - else 00
- ForwardB follows the same rules against EXRt.
- When MEM and WB both match, MEM wins because it holds the younger value.
- Stall, combinational: EXMemRead && EXRegWrite && EXDest!=0 && ((IDUsesRs && IDRs==EXDest) || (IDUsesRt && IDRt==EXDest)) && !Flush.
- Flush overrides Stall: a killed instruction never stalls.
- No FSM state is needed for the stall. After one stall cycle, the load has advanced to MEM and EX holds a bubble (EXRegWrite=0), so the request drops by itself. The dependent instruction then gets its operand through ForwardA/B=10 one cycle later.
- StallCount increments on each edge with Stall=1 and Freeze=0. It saturates at all ones.
- A MEM-stage load matching EXRs/EXRt still selects 01. This case cannot occur when Stall is honoured; the unit does not police it.

## Timing
- Forward and Stall outputs: zero latency, combinational from inputs and tracking registers, within the same cycle.
- Destination tracking latency: EX→MEM is 1 cycle, EX→WB is 2 cycles.
- Reset (Reset_n=0, immediate, asynchronous) drives:
  - all tracking registers to 0
  - StallCount to 0
  - therefore ForwardA/B=00 and Stall=0 (with EX inputs at 0)
- Reset mid-operation discards all in-flight destinations. The first edge after release samples EX normally.
- Freeze and Stall can be high together: Stall stays asserted and the counter does not advance.

## Structure
- Shared pipeline package holds:
  - forwarding select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - REG_W
  - REG_ZERO=5'd0
- Natural sub-module: fwd_select, the combinational single-operand comparator. Instantiate it twice, for A and B.
- The tracking registers and counter live in the top module.

## Test plan
- Reset: Reset_n=0 with random inputs → all outputs 0. Release → first edge loads MEMDest=EXDest.
- MEM forwarding: EX dest 9 with RegWrite=1; next cycle EXRs=9 → ForwardA=01. Next cycle EXRs=9 again → ForwardA=10.
- Priority and $0: MEM and WB both dest 7, EXRt=7 → ForwardB=01. Repeat with dest 0 and EXRt=0 → ForwardB=00.
- Load-use: EXMemRead=1, EXDest=5, IDRt=5, IDUsesRt=1 → Stall=1 and StallCount goes 0→1. Same hazard with Flush=1 → Stall=0. Same hazard with IDUsesRt=0 → Stall=0.
- Freeze: set MEMDest=3, then hold Freeze=1 for 3 cycles while EXDest=12 → MEMDest stays 3 and StallCount is unchanged.
- Saturation: preload via a run of 2^CNT_W stalls (or a reduced CNT_W=2 instance) → StallCount sticks at 3.
